id_operand_stage: RTL
=====================

// Module: id_operand_stage
// PURPOSE
//  Parametrised ID front end: IF/ID pipeline register, instruction hold buffer for the synchronous inst SRAM,
//  regfile read, N-channel priority bypass, load-use stall request. Sits between IF and the decode/EX logic;
//  emits a flat operand bus plus (optionally) a resolved branch bus back to IF.
// PARAMETERS
//  NUM_FWD  2   bypass channels; channel 0 = youngest (EX), 1 = MEM, ... up to 4
//  DATA_W   32  register/operand width
//  FWD_WD   DATA_W+7  per-channel width {we, is_load, waddr[4:0], wdata}
// PORTS
//  clk              in   1                    clock
//  rst              in   1                    synchronous, active-high reset
//  stall            in   `StallBus            stall vector; [1]=IF/ID reg, [2]=ID
//  stallreq         out  1                    load-use stall request to controller
//  if_to_id_bus     in   `IF_TO_ID_WD         {ce, pc[31:0]}
//  inst_sram_rdata  in   32                   inst SRAM data, valid the cycle after the IF request
//  fwd_bus          in   NUM_FWD*FWD_WD       concatenated bypass channels, channel 0 in LSBs
//  wb_to_rf_bus     in   `WB_TO_RF_WD         {we, waddr, wdata} regfile write port
//  id_op_bus        out  1+32+32+2*DATA_W     {ce, pc, inst, rs_val, rt_val}
//  br_bus           out  `BR_WD               {br_e, br_addr[31:0]}
// BEHAVIOUR
//  IF/ID register: rst -> 0; else stall[1]=Stop & stall[2]=NoStop -> 0 (bubble); else stall[1]=NoStop -> load.
//  Hold buffer: on the first cycle with stall[2]=Stop and hold_v=0, capture inst_sram_rdata into inst_hold, set hold_v.
//   hold_v clears on the first cycle stall[2]=NoStop. inst = hold_v ? inst_hold : inst_sram_rdata. rst clears both.
//  Bubble (ce=0): inst forced to 0, rs_val/rt_val 0, stallreq 0, br_e 0.
//  Operand use: uses_rs = ~(lui | j | jal); uses_rt = R-type | beq | bne | store (opcode 101xxx).
//  Bypass per operand: lowest-index channel with we=1 and waddr==reg wins; waddr 0 never bypasses, $0 reads 0.
//   No channel hit -> regfile data; regfile write-through for same-cycle WB write to the read address.
//  Load-use: stallreq = ce & ch0.we & ch0.is_load & ch0.waddr!=0 & ((uses_rs & rs==waddr)|(uses_rt & rt==waddr)).
//   Combinational, same cycle; controller converts it to stall[2:0]=Stop, so EX gets a bubble and the held inst
//   is re-evaluated next cycle when the load sits in channel 1 (no is_load stall from channels >=1).
//  Latency: IF/ID register 1 cycle; all operand outputs combinational from registered pc + inst + bypass.
//  Reset mid-stall: rst wins over stall, clears reg and hold buffer; outputs 0 next cycle.
//  Simultaneous stall release and new IF data: release cycle uses inst_hold, next cycle live SRAM data.
// CONFIGURATION
//  `ID_BRANCH_RESOLVE_EN` defined: beq/bne/j/jal/jr resolved here using bypassed operands;
//   br_addr = pc+4+sext(imm)<<2 | {pc+4[31:28],index,2'b0} | rs_val; br_e suppressed while stallreq=1.
//  Not defined: br_bus tied to 0; branch resolution is EX's job.
// STRUCTURE
//  Shared package/defines.vh: `FWD_WD, channel field offsets, opcode constants, ID_OP_WD.
//  Sub-module: id_bypass_mux (one operand: reg addr, rf data, fwd_bus -> value, hit, load_hit); instanced twice.
//  Existing regfile instanced unchanged.
// TESTING
//  ch0 {we=1,waddr=3,wdata=0x11} and ch1 {we=1,waddr=3,wdata=0x22}, addu rs=3 -> rs_val=0x11 (youngest wins).
//  ch0 {we=1,is_load=1,waddr=5}, subu rt=5 -> stallreq=1; next cycle load in ch1 -> stallreq=0, rt_val=ch1 data.
//  ch0 is_load waddr=5, ori rt=5 (rt not used as source) -> stallreq=0.
//  ch0 {we=1,waddr=0,wdata=0xFFFF} with rs=0 -> rs_val=0.
//  stall[2]=Stop 3 cycles while SRAM data changes 0x24010001->0x0 -> inst stays 0x24010001 until release.
//  With ID_BRANCH_RESOLVE_EN: beq $1,$2 pc=0x100, imm=4, both bypass to 7 -> br_e=1, br_addr=0x114.

Source files
------------

// File: rtl/id_operand_stage_pkg.sv
// Shared widths, bus field offsets, opcode constants and decode helpers for the ID operand stage.
package id_operand_stage_pkg;

    localparam int STALL_W     = 6;
    localparam logic STOP      = 1'b1;
    localparam logic NO_STOP   = 1'b0;

    localparam int IF_TO_ID_WD = 33;
    localparam int BR_WD       = 33;
    localparam int RF_AW       = 5;
    localparam int FWD_CTRL_W  = 2 + RF_AW;

    localparam logic [5:0] OP_SPECIAL  = 6'b000000;
    localparam logic [5:0] OP_J        = 6'b000010;
    localparam logic [5:0] OP_JAL      = 6'b000011;
    localparam logic [5:0] OP_BEQ      = 6'b000100;
    localparam logic [5:0] OP_BNE      = 6'b000101;
    localparam logic [5:0] OP_LUI      = 6'b001111;
    localparam logic [2:0] OP_STORE_HI = 3'b101;
    localparam logic [5:0] FN_JR       = 6'b001000;

    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } inst_fields_t;

    function automatic int fwd_wd(input int data_w);
        return data_w + FWD_CTRL_W;
    endfunction

    // Channel layout is {we, is_load, waddr, wdata}, wdata in the LSBs.
    function automatic int fwd_we_bit(input int data_w);
        return data_w + RF_AW + 1;
    endfunction

    function automatic int fwd_load_bit(input int data_w);
        return data_w + RF_AW;
    endfunction

    function automatic int id_op_wd(input int data_w);
        return 1 + 32 + 32 + 2 * data_w;
    endfunction

    function automatic int wb_to_rf_wd(input int data_w);
        return 1 + RF_AW + data_w;
    endfunction

    function automatic logic op_uses_rs(input logic [5:0] op);
        return !(op == OP_LUI || op == OP_J || op == OP_JAL);
    endfunction

    function automatic logic op_uses_rt(input logic [5:0] op);
        return (op == OP_SPECIAL) || (op == OP_BEQ) || (op == OP_BNE) || (op[5:3] == OP_STORE_HI);
    endfunction

endpackage

// File: rtl/id_operand_stage_bypass.sv
// One-operand priority bypass: lowest-index channel whose write address matches wins, else regfile data.
// Purely combinational; load_hit flags a match against a load still in channel 0 (EX).
module id_bypass_mux
    import id_operand_stage_pkg::*;
#(
    parameter int NUM_FWD = 2,
    parameter int DATA_W  = 32,
    parameter int FWD_WD  = DATA_W + 7
) (
    input  logic [RF_AW-1:0]          raddr,
    input  logic [DATA_W-1:0]         rf_data,
    input  logic [NUM_FWD*FWD_WD-1:0] fwd_bus,
    output logic [DATA_W-1:0]         value,
    output logic                      hit,
    output logic                      load_hit
);

    localparam int WE_BIT = fwd_we_bit(DATA_W);
    localparam int LD_BIT = fwd_load_bit(DATA_W);

    logic unused_load_flags;

    // Walk oldest to youngest so the youngest match overwrites.
    always_comb begin
        value = rf_data;
        hit   = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_bus[i*FWD_WD + WE_BIT] && fwd_bus[i*FWD_WD + DATA_W +: RF_AW] == raddr) begin
                value = fwd_bus[i*FWD_WD +: DATA_W];
                hit   = 1'b1;
            end
        end
        if (raddr == '0) begin
            value = '0;
            hit   = 1'b0;
        end
    end

    assign load_hit = fwd_bus[WE_BIT] & fwd_bus[LD_BIT]
                    & (fwd_bus[DATA_W +: RF_AW] == raddr) & (raddr != '0);

    always_comb begin
        unused_load_flags = 1'b0;
        for (int i = 1; i < NUM_FWD; i++) begin
            unused_load_flags = unused_load_flags ^ fwd_bus[i*FWD_WD + LD_BIT];
        end
    end

endmodule

// File: rtl/id_operand_stage_regfile.sv
// 32-entry register file, two combinational read ports, one write port; $0 hardwired to zero.
// Write takes effect at the clock edge; same-cycle forwarding of the write is left to the caller.
module regfile #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [4:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [4:0]        raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [4:0]        raddr2,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] regs [32];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && waddr != 5'd0) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];

endmodule

// File: rtl/id_operand_stage.sv
// ID front end: IF/ID register, inst hold buffer, regfile read, priority bypass, load-use stallreq; 1-cycle reg, operands comb.
// Stalls via stall[2:1]; optional branch resolution under ID_BRANCH_RESOLVE_EN (default: br_bus tied to 0).
module id_operand_stage
    import id_operand_stage_pkg::*;
#(
    parameter int NUM_FWD = 2,
    parameter int DATA_W  = 32,
    parameter int FWD_WD  = DATA_W + 7
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [STALL_W-1:0]              stall,
    output logic                            stallreq,
    input  logic [IF_TO_ID_WD-1:0]          if_to_id_bus,
    input  logic [31:0]                     inst_sram_rdata,
    input  logic [NUM_FWD*FWD_WD-1:0]       fwd_bus,
    input  logic [wb_to_rf_wd(DATA_W)-1:0]  wb_to_rf_bus,
    output logic [id_op_wd(DATA_W)-1:0]     id_op_bus,
    output logic [BR_WD-1:0]                br_bus
);

    logic              id_ce;
    logic [31:0]       id_pc;
    logic              hold_v;
    logic [31:0]       inst_hold;
    logic [31:0]       inst;
    inst_fields_t      f;

    logic              wb_we;
    logic [4:0]        wb_waddr;
    logic [DATA_W-1:0] wb_wdata;
    logic [DATA_W-1:0] rf_rdata1, rf_rdata2;
    logic [DATA_W-1:0] rf_rs, rf_rt;
    logic [DATA_W-1:0] rs_byp, rt_byp;
    logic              rs_hit, rt_hit, rs_load_hit, rt_load_hit;
    logic [DATA_W-1:0] rs_val, rt_val;
    logic              uses_rs, uses_rt;
    logic              unused_bits;

    always_ff @(posedge clk) begin
        if (rst) begin
            id_ce <= 1'b0;
            id_pc <= '0;
        end else if (stall[1] == STOP && stall[2] == NO_STOP) begin
            id_ce <= 1'b0;
            id_pc <= '0;
        end else if (stall[1] == NO_STOP) begin
            {id_ce, id_pc} <= if_to_id_bus;
        end
    end

    // The SRAM keeps presenting a new fetch while ID is stopped; keep the word it returned on the first stop cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_v    <= 1'b0;
            inst_hold <= '0;
        end else if (stall[2] == STOP && !hold_v) begin
            hold_v    <= 1'b1;
            inst_hold <= inst_sram_rdata;
        end else if (stall[2] == NO_STOP) begin
            hold_v    <= 1'b0;
        end
    end

    assign inst = id_ce ? (hold_v ? inst_hold : inst_sram_rdata) : 32'h0;
    assign f    = inst;

    assign {wb_we, wb_waddr, wb_wdata} = wb_to_rf_bus;

    regfile #(.DATA_W(DATA_W)) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_we),
        .waddr  (wb_waddr),
        .wdata  (wb_wdata),
        .raddr1 (f.rs),
        .rdata1 (rf_rdata1),
        .raddr2 (f.rt),
        .rdata2 (rf_rdata2)
    );

    assign rf_rs = (wb_we && wb_waddr == f.rs) ? wb_wdata : rf_rdata1;
    assign rf_rt = (wb_we && wb_waddr == f.rt) ? wb_wdata : rf_rdata2;

    id_bypass_mux #(.NUM_FWD(NUM_FWD), .DATA_W(DATA_W), .FWD_WD(FWD_WD)) u_byp_rs (
        .raddr    (f.rs),
        .rf_data  (rf_rs),
        .fwd_bus  (fwd_bus),
        .value    (rs_byp),
        .hit      (rs_hit),
        .load_hit (rs_load_hit)
    );

    id_bypass_mux #(.NUM_FWD(NUM_FWD), .DATA_W(DATA_W), .FWD_WD(FWD_WD)) u_byp_rt (
        .raddr    (f.rt),
        .rf_data  (rf_rt),
        .fwd_bus  (fwd_bus),
        .value    (rt_byp),
        .hit      (rt_hit),
        .load_hit (rt_load_hit)
    );

    assign rs_val  = id_ce ? rs_byp : '0;
    assign rt_val  = id_ce ? rt_byp : '0;
    assign uses_rs = op_uses_rs(f.opcode);
    assign uses_rt = op_uses_rt(f.opcode);

    // Only a load still in EX stalls; one cycle later it sits in MEM and bypasses normally.
    assign stallreq = id_ce & ((uses_rs & rs_load_hit) | (uses_rt & rt_load_hit));

    assign id_op_bus = {id_ce, id_pc, inst, rs_val, rt_val};

`ifdef ID_BRANCH_RESOLVE_EN
    logic [31:0] pc_plus4;
    logic [31:0] br_off;
    logic [31:0] br_addr;
    logic        br_take;
    logic        br_e;

    assign pc_plus4 = id_pc + 32'd4;
    assign br_off   = {{14{f.rd[4]}}, f.rd, f.shamt, f.funct, 2'b00};

    always_comb begin
        br_take = 1'b0;
        br_addr = '0;
        case (f.opcode)
            OP_BEQ: begin
                br_take = (rs_val == rt_val);
                br_addr = pc_plus4 + br_off;
            end
            OP_BNE: begin
                br_take = (rs_val != rt_val);
                br_addr = pc_plus4 + br_off;
            end
            OP_J, OP_JAL: begin
                br_take = 1'b1;
                br_addr = {pc_plus4[31:28], inst[25:0], 2'b00};
            end
            OP_SPECIAL: begin
                if (f.funct == FN_JR) begin
                    br_take = 1'b1;
                    br_addr = 32'(rs_val);
                end
            end
            default: begin
                br_take = 1'b0;
            end
        endcase
    end

    // A branch whose operands are still being loaded must not redirect IF yet.
    assign br_e   = id_ce & br_take & ~stallreq;
    assign br_bus = br_e ? {1'b1, br_addr} : '0;
    assign unused_bits = ^{stall[STALL_W-1:3], stall[0], rs_hit, rt_hit};
`else
    assign br_bus      = '0;
    assign unused_bits = ^{stall[STALL_W-1:3], stall[0], rs_hit, rt_hit, f.rd, f.shamt, f.funct};
`endif

endmodule
